pipe_ctrl: RTL and testbench

// Pipeline sequencer for the 5-stage RV32I core; consumes the hazard unit's load-use stall, the EX

---
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/memory/halt requests in, stage enables,
// flushes, status and perf counters out.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hu_stall;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             halt;
    logic             en_if;
    logic             en_id;
    logic             en_ex;
    logic             en_mem;
    logic             en_wb;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_mem;
    logic             flush_wb;
    logic             pc_redirect;
    logic             halted;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Core side: raises requests, consumes controls.
    modport master (
        output hu_stall, br_taken, mem_req, mem_ready, halt,
        input  en_if, en_id, en_ex, en_mem, en_wb,
        input  flush_id, flush_ex, flush_mem, flush_wb,
        input  pc_redirect, halted, err_timeout, stall_cnt, flush_cnt
    );

    // Sequencer side.
    modport slave (
        input  hu_stall, br_taken, mem_req, mem_ready, halt,
        output en_if, en_id, en_ex, en_mem, en_wb,
        output flush_id, flush_ex, flush_mem, flush_wb,
        output pc_redirect, halted, err_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: per-stage enables and bubble controls from
// halt / memory-wait / load-use / branch requests, plus saturating perf counters.
module pipe_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

    localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ERR = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_q, err_set;
    logic              br_accept;
    logic              hold;
    logic [4:0]        en;     // {if, id, ex, mem, wb}
    logic [3:0]        flush;  // {id, ex, mem, wb}
    logic              pc_redir;
    logic [CNT_W-1:0]  stall_q, flush_q;

    // Stage controls and next state, prioritised halt > mem wait > load-use > branch.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        en        = 5'b11111;
        flush     = 4'b0000;
        pc_redir  = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        br_accept = 1'b0;
        if (rst) begin
            en = 5'b00000;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.halt) begin
                        en        = 5'b00000;
                        state_nxt = ST_HALTED;
                    end else if (bus.mem_req && !bus.mem_ready) begin
                        en        = 5'b00001;
                        flush     = 4'b0001;
                        state_nxt = ST_MEM_WAIT;
                        wait_nxt  = WAIT_ONE;
                    end else if (bus.hu_stall) begin
                        // EX is held, so a same-cycle branch re-presents next cycle.
                        en    = 5'b00011;
                        flush = 4'b0010;
                    end else if (bus.br_taken) begin
                        flush     = 4'b1100;
                        pc_redir  = 1'b1;
                        br_accept = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state_nxt = ST_RUN;
                        wait_nxt  = '0;
                    end else begin
                        en    = 5'b00001;
                        flush = 4'b0001;
                        if (wait_cnt < WAIT_MAX) wait_nxt = wait_cnt + WAIT_ONE;
                        if (wait_cnt >= WAIT_ERR) err_set = 1'b1;
                    end
                end
                ST_HALTED: begin
                    en = 5'b00000;
                end
                default: begin
                    en        = 5'b00000;
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign hold = (en != 5'b11111) && (state != ST_HALTED);

    // State, wait timer, sticky timeout flag and saturating perf counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set) err_q <= 1'b1;
            if (hold && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
            if (br_accept && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
        end
    end

    assign bus.en_if       = en[4];
    assign bus.en_id       = en[3];
    assign bus.en_ex       = en[2];
    assign bus.en_mem      = en[1];
    assign bus.en_wb       = en[0];
    assign bus.flush_id    = flush[3];
    assign bus.flush_ex    = flush[2];
    assign bus.flush_mem   = flush[1];
    assign bus.flush_wb    = flush[0];
    assign bus.pc_redirect = pc_redir;
    assign bus.halted      = (state == ST_HALTED);
    assign bus.err_timeout = err_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the combinational RUN
// decode plus hand sequences for stall, memory wait, timeout, saturation and halt.
module tb_pipe_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       hu_stall;
        logic       br_taken;
        logic       mem_req;
        logic       mem_ready;
        logic       halt;
        logic [4:0] exp_en;     // {if, id, ex, mem, wb}
        logic [3:0] exp_flush;  // {id, ex, mem, wb}
        logic       exp_pc;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    function automatic logic [4:0] en_vec();
        return {bus.en_if, bus.en_id, bus.en_ex, bus.en_mem, bus.en_wb};
    endfunction

    function automatic logic [3:0] flush_vec();
        return {bus.flush_id, bus.flush_ex, bus.flush_mem, bus.flush_wb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic h, input logic b, input logic mr, input logic rd, input logic hl);
        bus.hu_stall  = h;
        bus.br_taken  = b;
        bus.mem_req   = mr;
        bus.mem_ready = rd;
        bus.halt      = hl;
    endtask

    // Apply inputs at the falling edge, sample 1 time unit later.
    task automatic step(input logic h, input logic b, input logic mr, input logic rd, input logic hl);
        @(negedge clk);
        drive(h, b, mr, rd, hl);
        #1;
    endtask

    // Leaves the bench just after a falling edge with rst low, inputs idle.
    task automatic do_reset(input bit chk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        if (chk) begin
            check("rst_en", en_vec(), 5'b00000);
            check("rst_flush", flush_vec(), 4'b0000);
            check("rst_pc", bus.pc_redirect, 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        //              hu br mr rd hl  en        flush    pc
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0}; // normal
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011, 4'b0010, 1'b0}; // load-use
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b1100, 1'b1}; // branch
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 4'b0010, 1'b0}; // stall beats branch
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 4'b0001, 1'b0}; // mem wait entry
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 4'b0000, 1'b0}; // mem ready at once
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b11111, 4'b1100, 1'b1}; // ready + branch
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 4'b0001, 1'b0}; // mem wait beats all
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 4'b0000, 1'b0}; // halt
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 4'b0000, 1'b0}; // halt beats all
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 4'b0000, 1'b0}; // ready w/o req

        // Reset state and first idle cycle.
        do_reset(1'b1);
        check("post_rst_en", en_vec(), 5'b11111);
        check("post_rst_flush", flush_vec(), 4'b0000);
        check("post_rst_stall_cnt", bus.stall_cnt, 0);
        check("post_rst_flush_cnt", bus.flush_cnt, 0);
        check("post_rst_halted", bus.halted, 1'b0);
        check("post_rst_err", bus.err_timeout, 1'b0);

        // RUN-state decode table.
        for (int i = 0; i < NVEC; i++) begin
            do_reset(1'b0);
            drive(vecs[i].hu_stall, vecs[i].br_taken, vecs[i].mem_req, vecs[i].mem_ready, vecs[i].halt);
            #1;
            check($sformatf("vec%0d_en", i), en_vec(), vecs[i].exp_en);
            check($sformatf("vec%0d_flush", i), flush_vec(), vecs[i].exp_flush);
            check($sformatf("vec%0d_pc", i), bus.pc_redirect, vecs[i].exp_pc);
        end

        // Single load-use stall cycle.
        do_reset(1'b0);
        step(1, 0, 0, 0, 0);
        check("lu_en", en_vec(), 5'b00011);
        check("lu_flush", flush_vec(), 4'b0010);
        step(0, 0, 0, 0, 0);
        check("lu_after_en", en_vec(), 5'b11111);
        check("lu_stall_cnt", bus.stall_cnt, 1);

        // Three-cycle memory wait; stall/branch ignored while waiting.
        do_reset(1'b0);
        step(0, 0, 1, 0, 0);
        check("mw1_en", en_vec(), 5'b00001);
        check("mw1_flush", flush_vec(), 4'b0001);
        step(0, 1, 1, 0, 0);
        check("mw2_en", en_vec(), 5'b00001);
        check("mw2_flush", flush_vec(), 4'b0001);
        check("mw2_pc", bus.pc_redirect, 1'b0);
        step(1, 0, 1, 0, 0);
        check("mw3_en", en_vec(), 5'b00001);
        check("mw3_flush", flush_vec(), 4'b0001);
        step(0, 0, 1, 1, 0);
        check("mw4_en", en_vec(), 5'b11111);
        check("mw4_flush", flush_vec(), 4'b0000);
        step(0, 0, 0, 0, 0);
        check("mw_stall_cnt", bus.stall_cnt, 3);
        check("mw_run_en", en_vec(), 5'b11111);

        // Branch shadowed by a stall re-presents next cycle.
        do_reset(1'b0);
        step(1, 1, 0, 0, 0);
        check("sb1_pc", bus.pc_redirect, 1'b0);
        check("sb1_flush", flush_vec(), 4'b0010);
        step(0, 1, 0, 0, 0);
        check("sb2_pc", bus.pc_redirect, 1'b1);
        check("sb2_flush", flush_vec(), 4'b1100);
        step(0, 0, 0, 0, 0);
        check("sb_flush_cnt", bus.flush_cnt, 1);
        check("sb_stall_cnt", bus.stall_cnt, 1);

        // flush_cnt saturates instead of wrapping.
        do_reset(1'b0);
        repeat (20) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("flush_cnt_sat", bus.flush_cnt, 15);

        // Reset in the middle of a memory wait.
        do_reset(1'b0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_mw_en", en_vec(), 5'b00000);
        check("rst_mw_flush", flush_vec(), 4'b0000);
        do_reset(1'b0);
        check("rst_mw_run_en", en_vec(), 5'b11111);
        check("rst_mw_stall_cnt", bus.stall_cnt, 0);

        // Memory timeout: entry cycle is wait 1, error after the 16th.
        do_reset(1'b0);
        for (int k = 1; k <= 16; k++) step(0, 0, 1, 0, 0);
        check("to_err_15", bus.err_timeout, 1'b0);
        step(0, 0, 1, 0, 0);
        check("to_err_16", bus.err_timeout, 1'b1);
        check("to_stall_sat", bus.stall_cnt, 15);
        repeat (3) step(0, 0, 1, 0, 0);
        check("to_err_hold", bus.err_timeout, 1'b1);
        check("to_wait_en", en_vec(), 5'b00001);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        check("to_err_sticky", bus.err_timeout, 1'b1);
        check("to_run_en", en_vec(), 5'b11111);

        // Halt: frozen for good regardless of inputs.
        step(0, 0, 0, 0, 1);
        check("halt_en", en_vec(), 5'b00000);
        check("halt_halted_0", bus.halted, 1'b0);
        for (int k = 0; k < 10; k++) begin
            logic [4:0] r;
            r = 5'($urandom);
            step(r[4], r[3], r[2], r[1], r[0]);
            check($sformatf("halted_%0d", k), bus.halted, 1'b1);
            check($sformatf("halted_en_%0d", k), en_vec(), 5'b00000);
            check($sformatf("halted_flush_%0d", k), {flush_vec(), bus.pc_redirect}, 5'b00000);
        end
        check("halted_stall_cnt", bus.stall_cnt, 15);
        do_reset(1'b0);
        check("unhalt_halted", bus.halted, 1'b0);
        check("unhalt_err", bus.err_timeout, 1'b0);
        check("unhalt_stall_cnt", bus.stall_cnt, 0);
        check("unhalt_en", en_vec(), 5'b11111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
